// File: rtl/io_delay_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// io_delay_sequencer_pkg
// Shared definitions for the Delay / Entrada / Saida sequencer:
//   - seq_state_e     : 3-bit sequencer state encoding
//   - DEFAULT_CLK_DIV : cycles per delay time unit (1 ms at 50 MHz)
//   - presc_width()   : prescaler counter width for a given divider
// ---------------------------------------------------------------------------
package io_delay_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DELAY      = 3'd1,
        ST_IN_WAIT    = 3'd2,
        ST_IN_RELEASE = 3'd3,
        ST_DONE       = 3'd4
    } seq_state_e;

    localparam int unsigned DEFAULT_CLK_DIV = 50000;

    // A divider of 1 still needs a one-bit counter so the wrap compare exists.
    function automatic int unsigned presc_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/io_delay_sequencer_btn_sync.sv
// ---------------------------------------------------------------------------
// io_delay_sequencer_btn_sync
// Brings an asynchronous push button into the clock domain through a
// SYNC_STAGES flop chain and flags its rising edge.
// Ports:
//   clock   : system clock
//   reset   : synchronous active-high reset, clears every flop
//   async_i : raw button level
//   level_o : synchronized button level
//   rise_o  : high for one cycle when level_o goes 0 -> 1
// ---------------------------------------------------------------------------
module io_delay_sequencer_btn_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clock) begin
                    if (reset) sync_q[gi] <= 1'b0;
                    else       sync_q[gi] <= async_i;
                end
            end else begin : g_rest
                always_ff @(posedge clock) begin
                    if (reset) sync_q[gi] <= 1'b0;
                    else       sync_q[gi] <= sync_q[gi-1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= sync_q[SYNC_STAGES-1];
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/io_delay_sequencer.sv
// ---------------------------------------------------------------------------
// io_delay_sequencer
// Multi-cycle sequencer for the DELAY, IN and OUT instructions. Holds the PC
// and register write path (stall) while a delay timer runs or while the user
// confirms the switch word with the enter button; latches OUT data into the
// display register.
// Ports:
//   clock, reset          : clock and synchronous active-high reset
//   delay, entrada, saida : decoded instruction strobes (priority in order)
//   delay_value           : delay length in time units
//   out_value             : word to show on the display
//   switches              : board switches, zero-extended on capture
//   enter_btn             : asynchronous enter button
//   stall                 : freeze PC / register write this cycle
//   io_data, io_write     : captured switch word and its write strobe
//   display_data          : display register
//   display_load          : one-cycle pulse after display_data updates
// ---------------------------------------------------------------------------
module io_delay_sequencer
    import io_delay_sequencer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SW_WIDTH    = 16,
    parameter int unsigned CLK_DIV     = DEFAULT_CLK_DIV,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  delay,
    input  logic                  entrada,
    input  logic                  saida,
    input  logic [DATA_WIDTH-1:0] delay_value,
    input  logic [DATA_WIDTH-1:0] out_value,
    input  logic [SW_WIDTH-1:0]   switches,
    input  logic                  enter_btn,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] io_data,
    output logic                  io_write,
    output logic [DATA_WIDTH-1:0] display_data,
    output logic                  display_load
);

    localparam int unsigned           PW         = presc_width(CLK_DIV);
    localparam logic [PW-1:0]         PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0]         PRESC_ONE  = PW'(1);
    localparam logic [DATA_WIDTH-1:0] REM_ONE    = DATA_WIDTH'(1);

    seq_state_e            state_q,   state_d;
    logic [PW-1:0]         presc_q,   presc_d;
    logic [DATA_WIDTH-1:0] remain_q,  remain_d;
    logic [DATA_WIDTH-1:0] io_data_q, io_data_d;
    logic [DATA_WIDTH-1:0] disp_q,    disp_d;
    logic                  load_q,    load_d;
    logic                  was_in_q,  was_in_d;

    logic btn_level;
    logic btn_rise;

    io_delay_sequencer_btn_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_enter_sync (
        .clock   (clock),
        .reset   (reset),
        .async_i (enter_btn),
        .level_o (btn_level),
        .rise_o  (btn_rise)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            remain_q  <= '0;
            io_data_q <= '0;
            disp_q    <= '0;
            load_q    <= 1'b0;
            was_in_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            remain_q  <= remain_d;
            io_data_q <= io_data_d;
            disp_q    <= disp_d;
            load_q    <= load_d;
            was_in_q  <= was_in_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        remain_d  = remain_q;
        io_data_d = io_data_q;
        disp_d    = disp_q;
        load_d    = 1'b0;
        was_in_d  = was_in_q;
        stall     = 1'b0;
        io_write  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (delay) begin
                    stall    = 1'b1;
                    was_in_d = 1'b0;
                    if (delay_value == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        remain_d = delay_value;
                        presc_d  = '0;
                        state_d  = ST_DELAY;
                    end
                end else if (entrada) begin
                    stall    = 1'b1;
                    was_in_d = 1'b1;
                    state_d  = ST_IN_WAIT;
                end else if (saida) begin
                    // OUT retires immediately; the pulse follows the update.
                    disp_d = out_value;
                    load_d = 1'b1;
                end
            end

            ST_DELAY: begin
                stall = 1'b1;
                if (presc_q == PRESC_LAST) begin
                    presc_d  = '0;
                    remain_d = remain_q - REM_ONE;
                    if (remain_q == REM_ONE) begin
                        state_d = ST_DONE;
                    end
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end

            ST_IN_WAIT: begin
                stall = 1'b1;
                // Only a fresh press counts, so a button held on entry waits.
                if (btn_rise) begin
                    io_data_d = DATA_WIDTH'(switches);
                    state_d   = ST_IN_RELEASE;
                end
            end

            ST_IN_RELEASE: begin
                stall = 1'b1;
                if (!btn_level) begin
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                io_write = was_in_q;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign io_data      = io_data_q;
    assign display_data = disp_q;
    assign display_load = load_q;

endmodule

// File: tb/tb_io_delay_sequencer.sv
// ---------------------------------------------------------------------------
// tb_io_delay_sequencer
// Directed and randomized checks of the DELAY / IN / OUT sequencer with
// CLK_DIV = 4. Expected values come from the instruction-level rules:
// stall length 1 + N*CLK_DIV (1 for N = 0), one write per IN carrying the
// zero-extended switches, one display pulse per OUT.
// ---------------------------------------------------------------------------
module tb_io_delay_sequencer;

    localparam int DW   = 32;
    localparam int SWW  = 16;
    localparam int CD   = 4;
    localparam int SS   = 2;
    localparam int MAXC = 1000;

    logic          clock = 1'b0;
    logic          reset;
    logic          delay, entrada, saida;
    logic [DW-1:0] delay_value, out_value;
    logic [SWW-1:0] switches;
    logic          enter_btn;
    logic          stall, io_write, display_load;
    logic [DW-1:0] io_data, display_data;

    io_delay_sequencer #(
        .DATA_WIDTH  (DW),
        .SW_WIDTH    (SWW),
        .CLK_DIV     (CD),
        .SYNC_STAGES (SS)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .delay        (delay),
        .entrada      (entrada),
        .saida        (saida),
        .delay_value  (delay_value),
        .out_value    (out_value),
        .switches     (switches),
        .enter_btn    (enter_btn),
        .stall        (stall),
        .io_data      (io_data),
        .io_write     (io_write),
        .display_data (display_data),
        .display_load (display_load)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse counters observed on every cycle.
    int io_write_seen = 0;
    int load_seen     = 0;
    always @(negedge clock) begin
        if (io_write)     io_write_seen++;
        if (display_load) load_seen++;
    end

    // Reference model state.
    logic [DW-1:0] exp_disp = '0;
    logic [DW-1:0] exp_io   = '0;
    int            exp_wr   = 0;
    int            exp_ld   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic do_delay(input logic [DW-1:0] val, input logic ent, input logic sai);
        int n;
        bit done;
        int exp_n;
        exp_n = (val == 0) ? 1 : 1 + int'(val) * CD;
        n = 0;
        done = 0;
        drive();
        delay = 1'b1; entrada = ent; saida = sai; delay_value = val;
        for (int i = 0; i < MAXC && !done; i++) begin
            sample();
            if (stall) begin
                n++;
                drive();
            end else begin
                done = 1;
            end
        end
        check("delay_done_reached", done, 1);
        check("delay_stall_len", n, exp_n);
        check("delay_done_no_write", io_write, 0);
        drive();
        delay = 1'b0; entrada = 1'b0; saida = 1'b0;
        sample();
        check("delay_idle_stall", stall, 0);
        $display("DELAY value=%0d ent=%0b sai=%0b stall_cycles=%0d", val, ent, sai, n);
    endtask

    task automatic do_in(input logic [SWW-1:0] sw, input bit held, input int gap);
        logic [DW-1:0] old_io;
        bit done;
        old_io = exp_io;
        done = 0;
        drive();
        enter_btn = held;
        repeat (4) drive();
        entrada = 1'b1; switches = sw;
        sample();
        check("in_entry_stall", stall, 1);
        repeat (10) drive();
        sample();
        check("in_wait_stall", stall, 1);
        check("in_no_early_capture", io_data, old_io);
        drive();
        enter_btn = 1'b0;
        repeat (gap) drive();
        enter_btn = 1'b1;
        repeat (6) drive();
        sample();
        check("in_release_stall", stall, 1);
        check("in_capture", io_data, {{(DW-SWW){1'b0}}, sw});
        drive();
        enter_btn = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            sample();
            if (!stall) done = 1;
            else        drive();
        end
        check("in_done_reached", done, 1);
        check("in_done_write", io_write, 1);
        drive();
        entrada = 1'b0;
        sample();
        check("in_write_one_cycle", io_write, 0);
        exp_io = {{(DW-SWW){1'b0}}, sw};
        exp_wr++;
        drive();
        check("in_write_count", io_write_seen, exp_wr);
        $display("IN switches=%04h held_on_entry=%0b gap=%0d io_data=%08h", sw, held, gap, io_data);
    endtask

    task automatic do_out(input logic [DW-1:0] v1, input logic [DW-1:0] v2, input bit two);
        logic [DW-1:0] last;
        last = two ? v2 : v1;
        drive();
        saida = 1'b1; out_value = v1;
        sample();
        check("out_no_stall", stall, 0);
        check("out_no_early_load", display_load, 0);
        drive();
        if (two) out_value = v2;
        else     saida = 1'b0;
        sample();
        check("out_data_1", display_data, v1);
        check("out_load_1", display_load, 1);
        if (two) begin
            check("out_no_stall_2", stall, 0);
            drive();
            saida = 1'b0;
            sample();
            check("out_data_2", display_data, v2);
            check("out_load_2", display_load, 1);
        end
        drive();
        sample();
        check("out_load_end", display_load, 0);
        check("out_data_kept", display_data, last);
        exp_disp = last;
        exp_ld += two ? 2 : 1;
        drive();
        check("out_load_count", load_seen, exp_ld);
        $display("OUT count=%0d last=%08h", two ? 2 : 1, last);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; delay = 1'b0; entrada = 1'b0; saida = 1'b0;
        delay_value = '0; out_value = '0; switches = '0; enter_btn = 1'b0;
        repeat (3) drive();
        reset = 1'b0;
        sample();
        check("rst_stall", stall, 0);
        check("rst_io_write", io_write, 0);
        check("rst_io_data", io_data, 0);
        check("rst_display", display_data, 0);
        check("rst_display_load", display_load, 0);
        $display("RESET released");

        // Directed plan.
        do_delay(3, 1'b0, 1'b0);
        do_delay(0, 1'b0, 1'b0);
        do_out(32'hDEADBEEF, '0, 1'b0);
        do_out(32'h12345678, 32'hCAFEF00D, 1'b1);
        do_in(16'hA5A5, 1'b1, 20);
        do_in(16'h5A5A, 1'b0, 5);
        do_in(16'h0F0F, 1'b1, 5);   // pressed again straight after the previous IN

        // Priority: DELAY wins, OUT/IN ignored for the whole instruction.
        do_delay(2, 1'b1, 1'b1);
        check("prio_display_kept", display_data, exp_disp);
        check("prio_no_load", load_seen, exp_ld);
        check("prio_no_write", io_write_seen, exp_wr);
        check("prio_io_data_kept", io_data, exp_io);

        // Reset in the middle of a long delay.
        drive();
        delay = 1'b1; delay_value = 100;
        repeat (10) drive();
        delay = 1'b0; reset = 1'b1;
        drive();
        reset = 1'b0;
        sample();
        check("midrst_stall", stall, 0);
        check("midrst_io_write", io_write, 0);
        check("midrst_display", display_data, 0);
        check("midrst_io_data", io_data, 0);
        exp_disp = '0;
        exp_io   = '0;
        drive();
        check("midrst_write_count", io_write_seen, exp_wr);
        $display("RESET during DELAY");
        do_delay(1, 1'b0, 1'b0);

        // Randomized instruction stream.
        for (int t = 0; t < 14; t++) begin
            int kind;
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                do_delay(DW'($urandom_range(0, 6)), 1'b0, 1'b0);
            end else if (kind == 1) begin
                do_in(SWW'($urandom), bit'($urandom_range(0, 1)), $urandom_range(4, 12));
            end else begin
                do_out(DW'($urandom), DW'($urandom), bit'($urandom_range(0, 1)));
            end
        end

        drive();
        check("final_write_count", io_write_seen, exp_wr);
        check("final_load_count", load_seen, exp_ld);
        check("final_display", display_data, exp_disp);
        check("final_io_data", io_data, exp_io);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
